// File: rtl/axi_spi_pkg.sv
// Shared constants for the AXI4-Lite register bank in front of SPI_master:
// register offsets, field positions, response codes and timing defaults.
package axi_spi_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_RXDATA = 8'h0C;
  localparam logic [7:0] OFF_TIMING = 8'h10;

  localparam int CTRL_MODE_LSB  = 0;
  localparam int CTRL_SPEED_LSB = 2;
  localparam int CTRL_WLEN_LSB  = 4;
  localparam int CTRL_FIELD_W   = 2;
  localparam int CTRL_START     = 8;
  localparam int CTRL_IE        = 9;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  localparam int TIM_IFG_LSB    = 0;
  localparam int TIM_CS_SCK_LSB = 8;
  localparam int TIM_SCK_CS_LSB = 16;
  localparam int TIM_FIELD_W    = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] DEF_T_IFG    = 8'd4;
  localparam logic [7:0] DEF_T_CS_SCK = 8'd2;
  localparam logic [7:0] DEF_T_SCK_CS = 8'd2;

  // Merge a write into an existing word, one byte lane per strobe bit.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite handshake engine: latches AW and W independently, issues one
// register write per transaction, and registers read data on the AR handshake.
module axi_lite_slave_if
  import axi_spi_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              GCLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic [1:0]        wr_resp,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic [1:0]        rd_resp
);

  logic              live;
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;

  // live keeps every ready low while reset is asserted and for the cycle after.
  assign s_axi_awready = live & ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = live & ~w_held & ~s_axi_bvalid;
  assign s_axi_arready = live & ~s_axi_rvalid;

  assign wr_en   = aw_held & w_held & ~s_axi_bvalid;
  assign wr_addr = aw_addr_q;
  assign wr_data = w_data_q;
  assign wr_strb = w_strb_q;

  assign rd_en   = s_axi_arvalid & s_axi_arready;
  assign rd_addr = s_axi_araddr;

  always_ff @(posedge GCLK) begin
    if (RST) begin
      live         <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      live <= 1'b1;

      if (s_axi_awvalid && s_axi_awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end

      if (wr_en) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end

      if (rd_en) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_spi_regs.sv
// Host-facing register bank for SPI_master: config/timing/TX registers,
// level start request, busy-falling capture of RX data and sticky DONE/irq.
module axi_spi_regs
  import axi_spi_pkg::*;
#(
  parameter int         ADDR_W       = 5,
  parameter logic [7:0] T_IFG_RST    = DEF_T_IFG,
  parameter logic [7:0] T_CS_SCK_RST = DEF_T_CS_SCK,
  parameter logic [7:0] T_SCK_CS_RST = DEF_T_SCK_CS
) (
  input  logic              GCLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [1:0]        spi_mode,
  output logic [1:0]        sck_speed,
  output logic [1:0]        word_len,
  output logic              start,
  output logic [31:0]       mosi_data,
  output logic [7:0]        t_IFG,
  output logic [7:0]        t_CS_SCK,
  output logic [7:0]        t_SCK_CS,
  input  logic              spi_busy,
  input  logic [31:0]       miso_data,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [1:0]        wr_resp;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;

  logic [1:0]  mode_q;
  logic [1:0]  speed_q;
  logic [1:0]  wlen_q;
  logic        ie_q;
  logic        start_q;
  logic        done_q;
  logic        busy_q;
  logic        irq_q;
  logic [31:0] txdata_q;
  logic [31:0] rxdata_q;
  logic [31:0] timing_q;

  logic [ADDR_W-1:0] wr_word;
  logic [ADDR_W-1:0] rd_word;
  logic        sel_ctrl, sel_status, sel_tx, sel_rx, sel_tim;
  logic        busy;
  logic        wr_locked;
  logic        wr_ok;
  logic        start_req;
  logic        done_clr;
  logic        busy_fall;
  logic [31:0] txdata_wr;
  logic [31:0] timing_wr;
  logic [31:0] ctrl_rd;
  logic [31:0] status_rd;

  axi_lite_slave_if #(.ADDR_W(ADDR_W)) u_if (
    .GCLK          (GCLK),
    .RST           (RST),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_resp       (wr_resp),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_resp       (rd_resp)
  );

  assign wr_word = wr_addr & ADDR_MASK;
  assign rd_word = rd_addr & ADDR_MASK;

  assign sel_ctrl   = (wr_word == ADDR_W'(OFF_CTRL));
  assign sel_status = (wr_word == ADDR_W'(OFF_STATUS));
  assign sel_tx     = (wr_word == ADDR_W'(OFF_TXDATA));
  assign sel_rx     = (wr_word == ADDR_W'(OFF_RXDATA));
  assign sel_tim    = (wr_word == ADDR_W'(OFF_TIMING));

  // A pending start counts as busy so config cannot change under an accepted request.
  assign busy      = spi_busy | start_q;
  assign wr_locked = busy & (sel_ctrl | sel_tx | sel_tim);
  assign wr_ok     = wr_en & ~wr_locked;
  assign wr_resp   = ((sel_ctrl | sel_status | sel_tx | sel_rx | sel_tim) && !wr_locked)
                     ? RESP_OKAY : RESP_SLVERR;

  assign start_req = wr_ok & sel_ctrl & wr_strb[1] & wr_data[CTRL_START];
  assign done_clr  = wr_ok & sel_status & wr_strb[0] & wr_data[STAT_DONE];
  assign busy_fall = busy_q & ~spi_busy;

  assign txdata_wr = apply_strb(txdata_q, wr_data, wr_strb);
  assign timing_wr = apply_strb(timing_q, wr_data, wr_strb);

  always_ff @(posedge GCLK) begin
    if (RST) begin
      mode_q   <= '0;
      speed_q  <= '0;
      wlen_q   <= '0;
      ie_q     <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
      txdata_q <= '0;
      rxdata_q <= '0;
      timing_q <= {8'h00, T_SCK_CS_RST, T_CS_SCK_RST, T_IFG_RST};
    end else begin
      busy_q <= spi_busy;
      irq_q  <= done_q & ie_q;

      if (wr_ok && sel_ctrl) begin
        if (wr_strb[0]) begin
          mode_q  <= wr_data[CTRL_MODE_LSB  +: CTRL_FIELD_W];
          speed_q <= wr_data[CTRL_SPEED_LSB +: CTRL_FIELD_W];
          wlen_q  <= wr_data[CTRL_WLEN_LSB  +: CTRL_FIELD_W];
        end
        if (wr_strb[1]) ie_q <= wr_data[CTRL_IE];
      end
      if (wr_ok && sel_tx)  txdata_q <= txdata_wr;
      if (wr_ok && sel_tim) timing_q <= timing_wr & 32'h00FF_FFFF;

      // start is a level held until the master is seen busy.
      if (start_req)     start_q <= 1'b1;
      else if (spi_busy) start_q <= 1'b0;

      if (busy_fall) begin
        rxdata_q <= miso_data;
        done_q   <= 1'b1;
      end else if (done_clr) begin
        done_q <= 1'b0;
      end
    end
  end

  assign ctrl_rd   = {22'd0, ie_q, 1'b0, 2'b00, wlen_q, speed_q, mode_q};
  assign status_rd = {30'd0, done_q, busy};

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (rd_en) begin
      case (rd_word)
        ADDR_W'(OFF_CTRL):   rd_data = ctrl_rd;
        ADDR_W'(OFF_STATUS): rd_data = status_rd;
        ADDR_W'(OFF_TXDATA): rd_data = txdata_q;
        ADDR_W'(OFF_RXDATA): rd_data = rxdata_q;
        ADDR_W'(OFF_TIMING): rd_data = timing_q;
        default:             rd_resp = RESP_SLVERR;
      endcase
    end
  end

  assign spi_mode  = mode_q;
  assign sck_speed = speed_q;
  assign word_len  = wlen_q;
  assign start     = start_q;
  assign mosi_data = txdata_q;
  assign t_IFG     = timing_q[TIM_IFG_LSB    +: TIM_FIELD_W];
  assign t_CS_SCK  = timing_q[TIM_CS_SCK_LSB +: TIM_FIELD_W];
  assign t_SCK_CS  = timing_q[TIM_SCK_CS_LSB +: TIM_FIELD_W];
  assign irq       = irq_q;

endmodule

// File: tb/tb_axi_spi_regs.sv
// Directed bench for axi_spi_regs: register-map vector table plus hand-built
// sequences for handshake ordering, start/busy/done timing and reset abort.
module tb_axi_spi_regs;

  logic        GCLK;
  logic        RST;
  logic [4:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [4:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [1:0]  spi_mode, sck_speed, word_len;
  logic        start;
  logic [31:0] mosi_data;
  logic [7:0]  t_IFG, t_CS_SCK, t_SCK_CS;
  logic        spi_busy;
  logic [31:0] miso_data;
  logic        irq;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  int checks = 0;
  int failures = 0;

  axi_spi_regs dut (
    .GCLK(GCLK), .RST(RST),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .spi_mode(spi_mode), .sck_speed(sck_speed), .word_len(word_len),
    .start(start), .mosi_data(mosi_data),
    .t_IFG(t_IFG), .t_CS_SCK(t_CS_SCK), .t_SCK_CS(t_SCK_CS),
    .spi_busy(spi_busy), .miso_data(miso_data), .irq(irq)
  );

  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: handshake timeout", nm);
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_ok, w_ok, aw_hs, w_hs, got;
    int n;
    aw_ok = 0; w_ok = 0; got = 0; resp = 2'b11;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge GCLK);
      aw_hs = s_axi_awvalid & s_axi_awready;
      w_hs  = s_axi_wvalid & s_axi_wready;
      @(posedge GCLK); #1;
      if (aw_hs) begin aw_ok = 1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_ok = 1;  s_axi_wvalid = 1'b0; end
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!(aw_ok && w_ok)) timeout_fail("write_addr_data");
    n = 0;
    while (!got && n < 20) begin
      @(negedge GCLK);
      if (s_axi_bvalid) begin resp = s_axi_bresp; got = 1; end
      @(posedge GCLK); #1;
      n++;
    end
    s_axi_bready = 1'b0;
    if (!got) timeout_fail("write_resp");
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    bit hs, got;
    int n;
    hs = 0; got = 0; d = '0; r = 2'b11;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!hs && n < 20) begin
      @(negedge GCLK);
      hs = s_axi_arready;
      @(posedge GCLK); #1;
      n++;
    end
    s_axi_arvalid = 1'b0;
    if (!hs) timeout_fail("read_addr");
    n = 0;
    while (!got && n < 20) begin
      @(negedge GCLK);
      if (s_axi_rvalid) begin d = s_axi_rdata; r = s_axi_rresp; got = 1; end
      @(posedge GCLK); #1;
      n++;
    end
    s_axi_rready = 1'b0;
    if (!got) timeout_fail("read_data");
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;

    RST = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; spi_busy = 1'b0; miso_data = '0;

    vecs.push_back('{1'b0, 5'h10, 32'h0,        4'h0, 32'h0002_0204, OK});
    vecs.push_back('{1'b0, 5'h00, 32'h0,        4'h0, 32'h0,         OK});
    vecs.push_back('{1'b0, 5'h04, 32'h0,        4'h0, 32'h0,         OK});
    vecs.push_back('{1'b0, 5'h08, 32'h0,        4'h0, 32'h0,         OK});
    vecs.push_back('{1'b0, 5'h0C, 32'h0,        4'h0, 32'h0,         OK});
    vecs.push_back('{1'b0, 5'h14, 32'h0,        4'h0, 32'h0,         ERR});
    vecs.push_back('{1'b0, 5'h1C, 32'h0,        4'h0, 32'h0,         ERR});
    vecs.push_back('{1'b1, 5'h10, 32'h0033_2211, 4'h5, 32'h0,        OK});
    vecs.push_back('{1'b0, 5'h10, 32'h0,        4'h0, 32'h0033_0211, OK});
    vecs.push_back('{1'b1, 5'h10, 32'hFFFF_FFFF, 4'h0, 32'h0,        OK});
    vecs.push_back('{1'b0, 5'h10, 32'h0,        4'h0, 32'h0033_0211, OK});
    vecs.push_back('{1'b1, 5'h18, 32'h1234_5678, 4'hF, 32'h0,        ERR});
    vecs.push_back('{1'b1, 5'h0C, 32'hDEAD_BEEF, 4'hF, 32'h0,        OK});
    vecs.push_back('{1'b0, 5'h0C, 32'h0,        4'h0, 32'h0,         OK});
    vecs.push_back('{1'b1, 5'h00, 32'h0000_003F, 4'h2, 32'h0,        OK});
    vecs.push_back('{1'b0, 5'h00, 32'h0,        4'h0, 32'h0,         OK});
    vecs.push_back('{1'b1, 5'h10, 32'h0002_0204, 4'hF, 32'h0,        OK});
    vecs.push_back('{1'b0, 5'h13, 32'h0,        4'h0, 32'h0002_0204, OK});

    // Reset state
    repeat (3) @(posedge GCLK);
    @(negedge GCLK);
    chk("rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
    chk("rst_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
    chk("rst_resp_rdata", {s_axi_rdata[29:0], s_axi_bresp} ^ {30'd0, s_axi_rresp}, 32'h0);
    chk("rst_start_irq", {30'd0, start, irq}, 32'h0);
    chk("rst_ctrl_out", {26'd0, spi_mode, sck_speed, word_len}, 32'h0);
    chk("rst_mosi", mosi_data, 32'h0);
    chk("rst_timing", {8'h0, t_SCK_CS, t_CS_SCK, t_IFG}, 32'h0002_0204);
    @(posedge GCLK); #1;
    RST = 1'b0;
    @(posedge GCLK); #1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        chk($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].exp_resp});
      end
    end
    chk("irq_idle", {31'd0, irq}, 32'h0);

    // W issued three cycles ahead of AW
    s_axi_wdata = 32'hA5A5_0F0F; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge GCLK);
    chk("w_first_wready", {31'd0, s_axi_wready}, 32'h1);
    @(posedge GCLK); #1;
    s_axi_wvalid = 1'b0;
    repeat (2) @(posedge GCLK);
    #1;
    s_axi_awaddr = 5'h08; s_axi_awvalid = 1'b1;
    @(negedge GCLK);
    chk("aw_late_awready", {31'd0, s_axi_awready}, 32'h1);
    @(posedge GCLK); #1;
    s_axi_awvalid = 1'b0;
    chk("b_not_early", {31'd0, s_axi_bvalid}, 32'h0);
    @(posedge GCLK); #1;
    chk("b_after_aw", {31'd0, s_axi_bvalid}, 32'h1);
    chk("b_after_aw_resp", {30'd0, s_axi_bresp}, {30'd0, OK});
    chk("mosi_written", mosi_data, 32'hA5A5_0F0F);
    s_axi_bready = 1'b1;
    @(posedge GCLK); #1;
    s_axi_bready = 1'b0;
    chk("b_cleared", {31'd0, s_axi_bvalid}, 32'h0);

    // Configure and start
    axi_write(5'h00, 32'h0000_0325, 4'hF, resp);
    chk("ctrl_wr_resp", {30'd0, resp}, {30'd0, OK});
    chk("ctrl_fields", {24'd0, 2'b00, spi_mode, sck_speed, word_len}, 32'h0000_0016);
    chk("start_set", {31'd0, start}, 32'h1);
    axi_read(5'h04, rd, resp);
    chk("status_pending", rd, 32'h1);
    axi_read(5'h00, rd, resp);
    chk("ctrl_readback", rd, 32'h0000_0225);
    repeat (10) @(posedge GCLK);
    #1;
    chk("start_held", {31'd0, start}, 32'h1);
    spi_busy = 1'b1;
    @(negedge GCLK);
    chk("start_before_sample", {31'd0, start}, 32'h1);
    @(posedge GCLK); #1;
    chk("start_dropped", {31'd0, start}, 32'h0);

    // Busy lock
    axi_write(5'h08, 32'h1111_1111, 4'hF, resp);
    chk("locked_tx_resp", {30'd0, resp}, {30'd0, ERR});
    chk("locked_tx_kept", mosi_data, 32'hA5A5_0F0F);
    axi_write(5'h00, 32'h0000_0100, 4'hF, resp);
    chk("locked_ctrl_resp", {30'd0, resp}, {30'd0, ERR});
    chk("locked_no_start", {31'd0, start}, 32'h0);
    axi_read(5'h00, rd, resp);
    chk("locked_ctrl_kept", rd, 32'h0000_0225);
    axi_read(5'h14, rd, resp);
    chk("unmapped_rdata", rd, 32'h0);
    chk("unmapped_rresp", {30'd0, resp}, {30'd0, ERR});
    axi_read(5'h04, rd, resp);
    chk("status_busy", rd, 32'h1);

    // Completion
    miso_data = 32'h1234_5678;
    spi_busy = 1'b0;
    repeat (3) @(posedge GCLK);
    #1;
    chk("irq_set", {31'd0, irq}, 32'h1);
    axi_read(5'h0C, rd, resp);
    chk("rxdata", rd, 32'h1234_5678);
    axi_read(5'h04, rd, resp);
    chk("status_done", rd, 32'h2);
    axi_write(5'h04, 32'h2, 4'hF, resp);
    chk("w1c_resp", {30'd0, resp}, {30'd0, OK});
    repeat (2) @(posedge GCLK);
    #1;
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    axi_read(5'h04, rd, resp);
    chk("status_cleared", rd, 32'h0);

    // W1C landing on the busy falling edge: set wins
    spi_busy = 1'b1;
    miso_data = 32'hCAFE_F00D;
    repeat (3) @(posedge GCLK);
    #1;
    s_axi_awaddr = 5'h04; s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    @(negedge GCLK);
    chk("race_readies", {30'd0, s_axi_awready, s_axi_wready}, 32'h3);
    @(posedge GCLK); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    spi_busy = 1'b0;
    @(posedge GCLK); #1;
    chk("race_bvalid", {31'd0, s_axi_bvalid}, 32'h1);
    chk("race_bresp", {30'd0, s_axi_bresp}, {30'd0, OK});
    @(posedge GCLK); #1;
    s_axi_bready = 1'b0;
    axi_read(5'h04, rd, resp);
    chk("race_done_kept", rd, 32'h2);
    chk("race_irq", {31'd0, irq}, 32'h1);

    // R channel held by rready=0
    s_axi_araddr = 5'h0C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    @(negedge GCLK);
    chk("hold_arready", {31'd0, s_axi_arready}, 32'h1);
    @(posedge GCLK); #1;
    s_axi_arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge GCLK);
      chk($sformatf("hold_rvalid_%0d", k), {31'd0, s_axi_rvalid}, 32'h1);
      chk($sformatf("hold_rdata_%0d", k), s_axi_rdata, 32'hCAFE_F00D);
    end
    chk("hold_arready_blocked", {31'd0, s_axi_arready}, 32'h0);
    s_axi_rready = 1'b1;
    @(posedge GCLK); #1;
    s_axi_rready = 1'b0;
    chk("hold_released", {31'd0, s_axi_rvalid}, 32'h0);

    // Reset aborts pending B and R and drops start
    axi_write(5'h00, 32'h0000_0100, 4'h2, resp);
    chk("restart_set", {31'd0, start}, 32'h1);
    s_axi_awaddr = 5'h08; s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'hF;
    s_axi_araddr = 5'h10;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(posedge GCLK); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(posedge GCLK); #1;
    chk("abort_pending", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'h3);
    RST = 1'b1;
    @(posedge GCLK); #1;
    RST = 1'b0;
    chk("abort_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
    chk("abort_start", {31'd0, start}, 32'h0);
    chk("abort_irq", {31'd0, irq}, 32'h0);
    @(posedge GCLK); #1;
    axi_read(5'h00, rd, resp);
    chk("post_rst_ctrl", rd, 32'h0);
    axi_read(5'h08, rd, resp);
    chk("post_rst_tx", rd, 32'h0);
    axi_read(5'h0C, rd, resp);
    chk("post_rst_rx", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_spi_regs.md
Name: axi_spi_regs

Overview:
AXI4-Lite slave register bank that sits directly upstream of SPI_master and drives its config, control, timing and MOSI data inputs. It captures the master's busy flag and received MISO word into software-visible registers. It generates the level start request and a sticky completion flag with an optional interrupt. This is the host-facing half of the AXI-to-SPI bridge.

Parameters:
ADDR_W, 5, byte-address width of s_axi_awaddr/s_axi_araddr.
T_IFG_RST, 8'd4, reset value of the t_IFG field.
T_CS_SCK_RST, 8'd2, reset value of the t_CS_SCK field.
T_SCK_CS_RST, 8'd2, reset value of the t_SCK_CS field.

Ports:
GCLK in 1 clock
RST in 1 reset, synchronous, active-high
s_axi_awaddr in ADDR_W; s_axi_awvalid in 1; s_axi_awready out 1
s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1
s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1
s_axi_araddr in ADDR_W; s_axi_arvalid in 1; s_axi_arready out 1
s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1
spi_mode out 2; sck_speed out 2; word_len out 2 (to SPI_master config)
start out 1; mosi_data out 32; t_IFG/t_CS_SCK/t_SCK_CS out 8 each
spi_busy in 1 (SPI_master busy); miso_data in 32 (SPI_master miso_data)
irq out 1, level interrupt

Behaviour:
- Register map. Byte offsets are word-aligned; addr[1:0] is ignored.
  - 0x00 CTRL RW: [1:0] spi_mode, [3:2] sck_speed, [5:4] word_len, [8] START (write-1 action, reads 0), [9] IE.
  - 0x04 STATUS: [0] BUSY (RO, equals spi_busy | start), [1] DONE (sticky, W1C).
  - 0x08 TXDATA RW: drives mosi_data.
  - 0x0C RXDATA RO.
  - 0x10 TIMING RW: [7:0] t_IFG, [15:8] t_CS_SCK, [23:16] t_SCK_CS.
  - Other offsets: read data 0, write ignored, resp SLVERR (2'b10). Mapped accesses return OKAY (2'b00).
- WSTRB is honoured per byte lane. The START action requires wstrb[1]=1 with wdata[8]=1.
- Reset values:
  - All AXI valid/ready outputs 0; bresp/rresp/rdata 0.
  - CTRL 0; TXDATA 0; RXDATA 0; DONE 0; start 0; irq 0.
  - TIMING = {T_SCK_CS_RST, T_CS_SCK_RST, T_IFG_RST}.
- Write channel:
  - AW and W are accepted independently, in either order.
  - awready=1 while no address is latched and bvalid=0; wready likewise for data.
  - The register update and bvalid=1 occur on the cycle after both are latched.
  - bvalid holds until bready; the latches clear on the B handshake.
  - One outstanding write at a time.
- Read channel:
  - arready=1 while rvalid=0.
  - rdata/rresp are registered on the AR handshake; rvalid=1 the next cycle and holds stable until rready.
- Start request:
  - A START write while idle sets start=1.
  - start clears on the first cycle spi_busy is sampled 1, i.e. the master has accepted it.
  - start is a level and stays high through the master's IFG wait.
- Busy lock: while STATUS.BUSY=1, writes to CTRL, TXDATA and TIMING are dropped entirely (including START) and respond SLVERR. STATUS W1C remains allowed.
- Completion:
  - busy_q is a one-cycle delayed copy of spi_busy.
  - On spi_busy falling (busy_q=1, spi_busy=0): RXDATA <= miso_data, DONE <= 1.
  - If a DONE set and a DONE W1C occur in the same cycle, the set wins.
- irq = DONE & IE, registered.
- Simultaneous read and write: both are served. A read samples pre-update register values.
- RST mid-transaction aborts any pending B/R responses with no response. start drops the next cycle.

Decomposition:
- Package axi_spi_pkg holds:
  - register offset constants;
  - field bit positions/widths;
  - RESP_OKAY and RESP_SLVERR;
  - the default timing constants.
- One sub-module, axi_lite_slave_if, handles AW/W/B/AR/R handshakes. It exposes wr_en/wr_addr/wr_data/wr_strb with wr_resp, and rd_en/rd_addr with rd_data/rd_resp. The register file and start/done logic stay in axi_spi_regs.

Test Plan:
- Reset, then read 0x10 -> rdata=0x00020204, OKAY. Read 0x00 -> 0, irq=0.
- W before AW: write 0x08=0xA5A5_0F0F, wstrb=4'hF, with W issued 3 cycles before AW -> bvalid 1 cycle after AW is accepted; mosi_data=0xA5A50F0F.
- Write 0x00=0x0000_0325 -> spi_mode=1, sck_speed=1, word_len=2, IE=1, start=1. Model spi_busy rising 10 cycles later -> start drops the same cycle busy is sampled.
- Model raises then drops spi_busy with miso_data=0x1234_5678 -> read 0x0C=0x12345678, STATUS=0x2, irq=1. Write 0x04=0x2 -> DONE=0, irq=0.
- While spi_busy=1: write 0x08 -> SLVERR, mosi_data unchanged. Read 0x14 -> rdata=0, SLVERR.
- W1C of DONE issued on the same cycle as a busy falling edge -> DONE=1. Hold rready=0 for 5 cycles -> rvalid and rdata remain stable.
